decode_opfetch: RTL and testbench
=================================

# decode_opfetch

Clocked, parametrised ARM decode and operand-fetch stage between the instruction issuer and the ALU. It accepts one 32-bit instruction per valid/ready handshake and classifies it. It fetches up to three register operands sequentially over a single register-bank read port, expands immediates (rotated imm8, imm12, branch offset) and presents operands, the original instruction and a type code to the ALU under a second valid/ready handshake. Compared with earlier decode generations it adds load/store and branch decode, register-specified shifts, rotated immediates, back-pressure and flush.

## Interface
- DATA_W, 32, operand width (≥32); immediates zero/sign-extended to DATA_W
- RB_AW, 4, register-bank address width; register fields zero-extended to RB_AW
- ENABLE_REG_SHIFT, 1, 1: register-shift data-processing forms fetch Rs; 0: they decode as type 15
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  abort current instruction (synchronous)
- in_instr  in  32  instruction from issuer
- in_valid  in  1  in_instr valid
- in_ready  out  1  stage can accept
- rb_rd_en  out  1  one-cycle read request
- rb_rd_addr  out  RB_AW  read address, valid with rb_rd_en
- rb_rd_valid  in  1  response strobe, ≥1 cycle after request, one per request
- rb_rd_data  in  DATA_W  response data
- out_op1, out_op2, out_op3  out  DATA_W  operands
- out_instr  out  32  original instruction
- out_type  out  4  0 data-proc, 1 load/store, 2 branch, 15 undefined
- out_valid  out  1  outputs valid
- out_ready  in  1  ALU accepts

## Operation
- States: IDLE, FETCH_RN, FETCH_RM, FETCH_RS, FETCH_RD, OUT, DRAIN.
- IDLE: in_ready=1 (only state where it is 1). On in_valid: latch instr, clear op1..op3, decode, go to first required fetch state, else OUT.
- Data-proc (type 0): [27:26]=00 and ([25]=1 or [7]=0 or [4]=0). Fetch Rn=[19:16] unless opcode [24:21] is 1101 or 1111 (op1=0). [25]=1: op2 = imm8 [7:0] rotated right by 2*[11:8]. [25]=0: fetch Rm=[3:0] into op2; if [4]=1 and ENABLE_REG_SHIFT, also fetch Rs=[11:8] into op3.
- Load/store (type 1): [27:26]=01. Fetch Rn into op1. [25]=0: op2=zero-ext imm12 [11:0]; [25]=1: fetch Rm into op2. Store ([20]=0): fetch Rd=[15:12] into op3.
- Branch (type 2): [27:25]=101. op1 = sign-ext([23:0])<<2; no fetches.
- Anything else: type 15, no fetches, operands 0.
- Fetch order always Rn, Rm, Rs, Rd, skipping unused.
- Each FETCH state: rb_rd_en=1 in its first cycle only, then waits for rb_rd_valid, captures rb_rd_data, advances.
- OUT: out_valid=1, outputs stable until out_ready; on out_valid&out_ready → IDLE.
- flush: from FETCH with a request outstanding → DRAIN (discard response, then IDLE); otherwise → IDLE. out_valid drops the next cycle. Flush in IDLE: no effect on in_ready; a simultaneous in_valid is not accepted.
- reset overrides flush and all handshakes.

## Timing
- Reset values: in_ready=0 during reset and 1 afterwards; rb_rd_en=0, rb_rd_addr=0, out_valid=0, out_op1..3=0, out_instr=0, out_type=0; state IDLE; outstanding response discarded.
- All outputs registered.
- Accept at edge T → first rb_rd_en in cycle T+1; zero-fetch instruction → out_valid in cycle T+1.
- With RB latency L, each fetch costs L+1 cycles; out_valid follows the cycle after the last capture.
- rb_rd_valid outside an outstanding request is ignored.
- Back-to-back throughput: next accept no earlier than the cycle after out handshake.

## Test plan
- ADD r1,r2,r3 (0xE0821003), RB returns r2=5, r3=7, L=1 → reads addr 2 then 3; out_op1=5, out_op2=7, out_type=0, out_instr=0xE0821003.
- MOV r0,#0xFF000000 (0xE3A004FF) → no rb_rd_en; out_valid at T+1; op1=0, op2=0xFF000000.
- ADD r0,r1,r2,LSL r3 (0xE0810312), L=3 → reads 1,2,3; op3=r3 value; with ENABLE_REG_SHIFT=0 → type 15, no reads.
- STR r1,[r2,#4] (0xE5821004) → reads 2 then 1; type 1, op2=4, op3=r1; B 0xEAFFFFFE → type 2, op1=0xFFFFFFF8.
- out_ready low 5 cycles → out_valid and all outputs held, in_ready=0; accepts after release.
- flush one cycle after rb_rd_en with L=4 → DRAIN, late response discarded, no out_valid, in_ready returns after response; reset mid-fetch → all outputs at reset values next cycle.

Source files
------------

// File: rtl/decode_opfetch.sv
// ARM decode and operand-fetch stage: classifies one instruction, reads up
// to three registers over a single bank port and hands the bundle to the ALU.
module decode_opfetch #(
  parameter int DATA_W           = 32,
  parameter int RB_AW            = 4,
  parameter bit ENABLE_REG_SHIFT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [31:0]       in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rb_rd_en,
  output logic [RB_AW-1:0]  rb_rd_addr,
  input  logic              rb_rd_valid,
  input  logic [DATA_W-1:0] rb_rd_data,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_op3,
  output logic [31:0]       out_instr,
  output logic [3:0]        out_type,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_RN,
    FETCH_RM,
    FETCH_RS,
    FETCH_RD,
    OUT,
    DRAIN
  } state_t;

  state_t state, nxt;

  logic [3:0]        need, d_need, rest, cur;
  logic [3:0]        d_type;
  logic [DATA_W-1:0] d_op1, d_op2;
  logic [31:0]       imm32, rot_imm, src;
  logic [4:0]        rot_amt;
  logic [3:0]        field;
  logic              dp, ls, br;
  logic              stale, fetching, accept;
  logic              resp, capture, issue;

  function automatic state_t first_of(input logic [3:0] m);
    if (m[0]) return FETCH_RN;
    if (m[1]) return FETCH_RM;
    if (m[2]) return FETCH_RS;
    if (m[3]) return FETCH_RD;
    return OUT;
  endfunction

  always_comb begin
    d_type  = 4'hF;
    d_need  = 4'b0;
    d_op1   = '0;
    d_op2   = '0;
    imm32   = {24'b0, in_instr[7:0]};
    rot_amt = {in_instr[11:8], 1'b0};
    rot_imm = (imm32 >> rot_amt)
            | (imm32 << (6'd32 - {1'b0, rot_amt}));
    dp = (in_instr[27:26] == 2'b00)
       && (in_instr[25] || !in_instr[7] || !in_instr[4]);
    ls = (in_instr[27:26] == 2'b01);
    br = (in_instr[27:25] == 3'b101);
    unique case (1'b1)
      dp && (in_instr[25] || !in_instr[4] || ENABLE_REG_SHIFT): begin
        d_type = 4'd0;
        // MOV and MVN ignore Rn
        d_need[0] = !(in_instr[24:23] == 2'b11 && in_instr[21]);
        if (in_instr[25]) begin
          d_op2 = DATA_W'(rot_imm);
        end else begin
          d_need[1] = 1'b1;
          d_need[2] = in_instr[4];
        end
      end
      ls: begin
        d_type    = 4'd1;
        d_need[0] = 1'b1;
        d_need[1] = in_instr[25];
        d_need[3] = !in_instr[20];
        if (!in_instr[25]) d_op2 = DATA_W'(in_instr[11:0]);
      end
      br: begin
        d_type = 4'd2;
        d_op1  = DATA_W'($signed(in_instr[23:0])) << 2;
      end
      default: ;
    endcase
  end

  always_comb begin
    fetching = state inside {FETCH_RN, FETCH_RM, FETCH_RS, FETCH_RD};
    accept   = in_ready && in_valid && !flush;
    // a response in the request cycle cannot belong to that request
    resp     = rb_rd_valid && !stale && !rb_rd_en;
    capture  = fetching && resp && !flush;
    cur      = 4'b0;
    case (state)
      FETCH_RN: cur = 4'b0001;
      FETCH_RM: cur = 4'b0010;
      FETCH_RS: cur = 4'b0100;
      FETCH_RD: cur = 4'b1000;
      default:  cur = 4'b0;
    endcase
    rest = need & ~cur;
    nxt  = state;
    case (state)
      IDLE:  if (accept) nxt = first_of(d_need);
      FETCH_RN, FETCH_RM, FETCH_RS, FETCH_RD: begin
        if (flush)        nxt = resp ? IDLE : DRAIN;
        else if (capture) nxt = first_of(rest);
      end
      OUT:   if (flush || out_ready) nxt = IDLE;
      DRAIN: if (resp) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    issue = (nxt inside {FETCH_RN, FETCH_RM, FETCH_RS, FETCH_RD})
          && (nxt != state);
    src   = (state == IDLE) ? in_instr : out_instr;
    case (nxt)
      FETCH_RN: field = src[19:16];
      FETCH_RM: field = src[3:0];
      FETCH_RS: field = src[11:8];
      FETCH_RD: field = src[15:12];
      default:  field = 4'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      rb_rd_en   <= 1'b0;
      rb_rd_addr <= '0;
      out_valid  <= 1'b0;
      out_op1    <= '0;
      out_op2    <= '0;
      out_op3    <= '0;
      out_instr  <= '0;
      out_type   <= '0;
      need       <= '0;
      // remember a read that is still in flight so its reply is dropped
      stale <= (stale || fetching || state == DRAIN) && !rb_rd_valid;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt == IDLE);
      out_valid <= (nxt == OUT);
      rb_rd_en  <= issue;
      if (issue) rb_rd_addr <= RB_AW'(field);
      if (rb_rd_valid) stale <= 1'b0;
      if (accept) begin
        out_instr <= in_instr;
        out_type  <= d_type;
        out_op1   <= d_op1;
        out_op2   <= d_op2;
        out_op3   <= '0;
        need      <= d_need;
      end
      if (capture) begin
        need <= rest;
        case (state)
          FETCH_RN: out_op1 <= rb_rd_data;
          FETCH_RM: out_op2 <= rb_rd_data;
          default:  out_op3 <= rb_rd_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_opfetch.sv
// Bench for decode_opfetch: behavioural model, latency-programmable register
// bank responder, directed spec cases and randomized instruction stream.
module tb_decode_opfetch;

  logic        clk = 0;
  logic        reset = 1;
  logic        flush = 0;
  logic [31:0] in_instr = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic        rb_rd_en;
  logic [3:0]  rb_rd_addr;
  logic        rb_rd_valid = 0;
  logic [31:0] rb_rd_data = 0;
  logic [31:0] out_op1, out_op2, out_op3, out_instr;
  logic [3:0]  out_type;
  logic        out_valid;
  logic        out_ready = 0;

  logic        in2_valid = 0;
  logic [31:0] in2_instr = 0;
  logic        in2_ready, rb2_en, out2_valid;
  logic [3:0]  rb2_addr, out2_type;
  logic [31:0] out2_op1, out2_op2, out2_op3, out2_instr;
  logic        flush2 = 0, rb2_valid = 0, out2_ready = 1;
  logic [31:0] rb2_data = 0;

  decode_opfetch dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .rb_rd_en(rb_rd_en), .rb_rd_addr(rb_rd_addr),
    .rb_rd_valid(rb_rd_valid), .rb_rd_data(rb_rd_data),
    .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3),
    .out_instr(out_instr), .out_type(out_type),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  decode_opfetch #(.ENABLE_REG_SHIFT(1'b0)) dut2 (
    .clk(clk), .reset(reset), .flush(flush2),
    .in_instr(in2_instr), .in_valid(in2_valid), .in_ready(in2_ready),
    .rb_rd_en(rb2_en), .rb_rd_addr(rb2_addr),
    .rb_rd_valid(rb2_valid), .rb_rd_data(rb2_data),
    .out_op1(out2_op1), .out_op2(out2_op2), .out_op3(out2_op3),
    .out_instr(out2_instr), .out_type(out2_type),
    .out_valid(out2_valid), .out_ready(out2_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [16];
  logic [3:0]  m_ty;
  logic [31:0] m_o1, m_o2, m_o3;
  logic [3:0]  m_rd [$];

  logic [31:0] e_o1, e_o2, e_o3, e_instr;
  logic [3:0]  e_ty;
  bit          e_live = 0;
  logic [3:0]  exp_addr [$];
  int          lat = 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Architectural view: which registers are read, in order, and what the
  // ALU must see, given the current register bank contents.
  task automatic model(input logic [31:0] i, input bit ers);
    logic [63:0] w;
    logic signed [31:0] s;
    int r;
    m_rd.delete();
    m_ty = 4'd15;
    m_o1 = 0;
    m_o2 = 0;
    m_o3 = 0;
    if (i[27:26] == 2'b00 && (i[25] || !i[7] || !i[4])
        && (ers || i[25] || !i[4])) begin
      m_ty = 0;
      if (i[24:21] != 4'd13 && i[24:21] != 4'd15) begin
        m_rd.push_back(i[19:16]);
        m_o1 = regs[i[19:16]];
      end
      if (i[25]) begin
        r = 2 * int'(i[11:8]);
        w = {24'b0, i[7:0], 24'b0, i[7:0]} >> r;
        m_o2 = w[31:0];
      end else begin
        m_rd.push_back(i[3:0]);
        m_o2 = regs[i[3:0]];
        if (i[4]) begin
          m_rd.push_back(i[11:8]);
          m_o3 = regs[i[11:8]];
        end
      end
    end else if (i[27:26] == 2'b01) begin
      m_ty = 1;
      m_rd.push_back(i[19:16]);
      m_o1 = regs[i[19:16]];
      if (i[25]) begin
        m_rd.push_back(i[3:0]);
        m_o2 = regs[i[3:0]];
      end else begin
        m_o2 = {20'b0, i[11:0]};
      end
      if (!i[20]) begin
        m_rd.push_back(i[15:12]);
        m_o3 = regs[i[15:12]];
      end
    end else if (i[27:25] == 3'b101) begin
      m_ty = 2;
      s = {{8{i[23]}}, i[23:0]};
      m_o1 = s * 4;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // compare process
  initial forever begin
    @(negedge clk);
    if (!reset && out_valid) begin
      if (!e_live) begin
        chk("unexpected out_valid", out_valid, 0);
      end else begin
        chk("out_op1", out_op1, e_o1);
        chk("out_op2", out_op2, e_o2);
        chk("out_op3", out_op3, e_o3);
        chk("out_instr", out_instr, e_instr);
        chk("out_type", out_type, e_ty);
      end
    end
  end

  // register bank: in-order replies, lat cycles after each request
  int          cyc = 0;
  int          rq_t [$];
  logic [31:0] rq_d [$];
  initial forever begin
    int t;
    bit spur;
    @(negedge clk);
    if (rb_rd_en) begin
      if (exp_addr.size() == 0) chk("unexpected read", 1, 0);
      else chk("read addr", rb_rd_addr, exp_addr.pop_front());
      t = cyc + lat;
      if (rq_t.size() != 0 && t <= rq_t[$]) t = rq_t[$] + 1;
      rq_t.push_back(t);
      rq_d.push_back(regs[rb_rd_addr]);
    end
    spur = out_valid && rq_t.size() == 0;
    @(posedge clk);
    cyc++;
    #1;
    rb_rd_valid = 0;
    rb_rd_data = $urandom;
    if (rq_t.size() != 0 && rq_t[0] == cyc) begin
      rb_rd_valid = 1;
      rb_rd_data = rq_d.pop_front();
      void'(rq_t.pop_front());
    end else if (spur && $urandom_range(3) == 0) begin
      rb_rd_valid = 1;
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run(input logic [31:0] ins, input int l,
                     input int hold, input bit fo);
    int n, k;
    lat = l;
    model(ins, 1'b1);
    n = m_rd.size();
    wait_ready();
    if (!in_ready) begin
      chk("in_ready wait", in_ready, 1);
      return;
    end
    exp_addr = m_rd;
    e_o1 = m_o1;
    e_o2 = m_o2;
    e_o3 = m_o3;
    e_ty = m_ty;
    e_instr = ins;
    e_live = 1;
    in_valid = 1;
    in_instr = ins;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      in_valid = 0;
      k++;
    end while (!out_valid && k < 200);
    chk("out latency", k, 1 + n * (l + 1));
    if (!out_valid) begin
      e_live = 0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("in_ready while held", in_ready, 0);
      @(negedge clk);
    end
    if (fo) flush = 1;
    else out_ready = 1;
    @(posedge clk);
    #1;
    flush = 0;
    out_ready = 0;
    e_live = 0;
    @(negedge clk);
    chk("out_valid drop", out_valid, 0);
    chk("in_ready return", in_ready, 1);
    chk("reads done", exp_addr.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = $urandom;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst rb_rd_en", rb_rd_en, 0);
    chk("rst rb_rd_addr", rb_rd_addr, 0);
    chk("rst ops", {out_op1, out_op2}, 0);
    chk("rst op3/instr", {out_op3, out_instr}, 0);
    chk("rst out_type", out_type, 0);
    @(posedge clk);
    #1 reset = 0;

    // pin the model with hand-worked values
    regs[1] = 32'd11;
    regs[2] = 32'd5;
    regs[3] = 32'd7;
    model(32'hE0821003, 1'b1);
    chk("pin add type", m_ty, 0);
    chk("pin add ops", {m_o1, m_o2}, {32'd5, 32'd7});
    chk("pin add nreads", m_rd.size(), 2);
    if (m_rd.size() == 2) chk("pin add addrs", {m_rd[0], m_rd[1]}, 8'h23);
    model(32'hE3A004FF, 1'b1);
    chk("pin mov op2", m_o2, 32'hFF000000);
    chk("pin mov nreads", m_rd.size(), 0);
    model(32'hEAFFFFFE, 1'b1);
    chk("pin b", {m_ty, m_o1}, {4'd2, 32'hFFFFFFF8});
    model(32'hE5821004, 1'b1);
    chk("pin str", {m_ty, m_o2, m_o3}, {4'd1, 32'd4, 32'd11});
    model(32'hE0810312, 1'b0);
    chk("pin noshift", {m_ty, 32'(m_rd.size())}, {4'd15, 32'd0});
    model(32'hE0810312, 1'b1);
    chk("pin shift op3", m_o3, 32'd7);

    run(32'hE0821003, 1, 0, 0);
    run(32'hE3A004FF, 2, 0, 0);
    run(32'hE0810312, 3, 1, 0);
    run(32'hE5821004, 2, 0, 0);
    run(32'hEAFFFFFE, 1, 0, 0);
    run(32'hE0821003, 2, 5, 0);
    run(32'hE3A004FF, 1, 2, 1);

    // flush one cycle after the read request, slow bank
    lat = 4;
    exp_addr.delete();
    exp_addr.push_back(4'd2);
    wait_ready();
    in_valid = 1;
    in_instr = 32'hE0821003;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("drain in_ready", in_ready, 0);
    end
    @(negedge clk);
    chk("drain released", in_ready, 1);
    chk("drain reads", exp_addr.size(), 0);

    // reset while a read is outstanding
    exp_addr.push_back(4'd2);
    wait_ready();
    in_valid = 1;
    in_instr = 32'hE0821003;
    @(posedge clk);
    #1 in_valid = 0;
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    exp_addr.delete();
    @(negedge clk);
    chk("mid rst in_ready", in_ready, 0);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst rb", {rb_rd_en, rb_rd_addr}, 0);
    chk("mid rst ops", {out_op1, out_op2, out_op3}, 0);
    chk("mid rst instr", {out_instr, out_type}, 0);
    run(32'hE0854006, 3, 1, 0);

    // register-shift forms disabled
    begin
      int k = 0;
      while (!in2_ready && k < 100) begin
        @(negedge clk);
        k++;
      end
      in2_valid = 1;
      in2_instr = 32'hE0810312;
      @(posedge clk);
      @(negedge clk);
      in2_valid = 0;
      chk("noshift valid", out2_valid, 1);
      chk("noshift type", out2_type, 15);
      chk("noshift ops", {out2_op1, out2_op2, out2_op3}, 0);
      chk("noshift no read", rb2_en, 0);
    end

    for (int t = 0; t < 60; t++) begin
      logic [31:0] ins;
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      ins = $urandom;
      if ($urandom_range(3) == 0) ins[27:25] = 3'b101;
      run(ins, $urandom_range(1, 4), $urandom_range(0, 4),
          $urandom_range(7) == 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
